// File: rtl/decred_sched_pkg.sv
// Shared types and constants for the nonce scheduler.
// FSM encoding, nonce width and default slice size.
package decred_sched_pkg;

  localparam int NONCE_W        = 32;
  localparam int DEF_SLICE_SIZE = 256;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Priority starts one past the last advanced winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand, win;
  logic          found;

  // scan from last winner + 1, wrapping, pick first requester
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    win   = last_q;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_q) + i >= N) ?
             IW'(int'(last_q) + i - N) :
             IW'(int'(last_q) + i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) grant[win] = 1'b1;
    last_d = (advance && found) ? win : last_q;
  end

  // pointer reset so unit 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST_INIT;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce range scheduler: slices a job across hash units, collects solutions.
// Optional NONCE_SCHED_STATS_EN adds slice/solution counters.
module nonce_scheduler
  import decred_sched_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int SLICE_SIZE = DEF_SLICE_SIZE
) (
  input  logic                           M1_CLK,
  input  logic                           EXT_RESET_N,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NONCE_W-1:0]             nonce_base,
  input  logic [NONCE_W-1:0]             nonce_limit,
  input  logic [NUM_UNITS-1:0]           unit_ready,
  output logic [NUM_UNITS-1:0]           unit_load,
  output logic [NONCE_W-1:0]             unit_first,
  output logic [NONCE_W-1:0]             unit_last,
  input  logic [NUM_UNITS-1:0]           unit_sol_valid,
  input  logic [NUM_UNITS*NONCE_W-1:0]   unit_sol_nonce,
  output logic [NUM_UNITS-1:0]           unit_sol_ack,
  output logic                           sol_valid,
  output logic [NONCE_W-1:0]             sol_nonce,
  input  logic                           sol_read,
  output logic                           busy,
  output logic                           done,
  output logic                           irq,
  output logic [31:0]                    stat_slices,
  output logic [31:0]                    stat_solutions
);

  localparam logic [NONCE_W:0]   SPAN = (NONCE_W+1)'(SLICE_SIZE - 1);
  localparam logic [NONCE_W-1:0] STEP = NONCE_W'(SLICE_SIZE);

  sched_state_e state_q, state_d;

  logic [NONCE_W-1:0]   next_q, next_d;
  logic [NONCE_W-1:0]   limit_q, limit_d;
  logic [NUM_UNITS-1:0] load_q, load_d;
  logic [NONCE_W-1:0]   first_q, first_d;
  logic [NONCE_W-1:0]   last_q, last_d;
  logic                 done_q, done_d;
  logic                 sval_q, sval_d;
  logic [NONCE_W-1:0]   snonce_q, snonce_d;

  logic [NUM_UNITS-1:0] d_req, d_gnt;
  logic [NUM_UNITS-1:0] s_req, s_gnt;
  logic [NONCE_W:0]     sum;
  logic [NONCE_W-1:0]   last_c;

  // 33-bit slice end, clamped to the job limit
  always_comb begin
    sum    = {1'b0, next_q} + SPAN;
    last_c = (sum > {1'b0, limit_q}) ? limit_q : sum[NONCE_W-1:0];
  end

  // units loaded last cycle may still show ready, so mask them
  always_comb begin
    d_req = '0;
    if (state_q == DISPATCH && !abort) d_req = unit_ready & ~load_q;
  end

  rr_arbiter #(.N(NUM_UNITS)) u_disp_arb (
    .clk     (M1_CLK),
    .rst_n   (EXT_RESET_N),
    .req     (d_req),
    .advance (|d_gnt),
    .grant   (d_gnt)
  );

  // job FSM next state and slice outputs
  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    limit_d = limit_q;
    load_d  = '0;
    first_d = first_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            next_d  = nonce_base;
            limit_d = nonce_limit;
            state_d = (nonce_limit < nonce_base) ? DONE : DISPATCH;
          end
        end
        DISPATCH: begin
          if (|d_gnt) begin
            load_d  = d_gnt;
            first_d = next_q;
            last_d  = last_c;
            if (last_c == limit_q) state_d = DRAIN;
            else                   next_d  = next_q + STEP;
          end
        end
        DRAIN: begin
          if ((&unit_ready) && (load_q == '0)) state_d = DONE;
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // job state and registered slice strobes
  always_ff @(posedge M1_CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      state_q <= IDLE;
      next_q  <= '0;
      limit_q <= '0;
      load_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      limit_q <= limit_d;
      load_q  <= load_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // a capture slot opens when empty or being read this cycle
  always_comb begin
    s_req = '0;
    if (!sval_q || sol_read) s_req = unit_sol_valid;
  end

  rr_arbiter #(.N(NUM_UNITS)) u_sol_arb (
    .clk     (M1_CLK),
    .rst_n   (EXT_RESET_N),
    .req     (s_req),
    .advance (|s_gnt),
    .grant   (s_gnt)
  );

  // host solution register update
  always_comb begin
    snonce_d = snonce_q;
    sval_d   = sval_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (s_gnt[i]) snonce_d = unit_sol_nonce[i*NONCE_W +: NONCE_W];
    end
    if (|s_gnt)        sval_d = 1'b1;
    else if (sol_read) sval_d = 1'b0;
  end

  // solution register flops
  always_ff @(posedge M1_CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      sval_q   <= 1'b0;
      snonce_q <= '0;
    end else begin
      sval_q   <= sval_d;
      snonce_q <= snonce_d;
    end
  end

`ifdef NONCE_SCHED_STATS_EN
  logic [31:0] slices_q, slices_d;
  logic [31:0] sols_q, sols_d;

  // count visible loads and acknowledged captures
  always_comb begin
    slices_d = slices_q + ((|load_q) ? 32'd1 : 32'd0);
    sols_d   = sols_q + ((|s_gnt) ? 32'd1 : 32'd0);
  end

  // statistics counters, cleared only by reset
  always_ff @(posedge M1_CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      slices_q <= '0;
      sols_q   <= '0;
    end else begin
      slices_q <= slices_d;
      sols_q   <= sols_d;
    end
  end

  assign stat_slices    = slices_q;
  assign stat_solutions = sols_q;
`else
  assign stat_slices    = '0;
  assign stat_solutions = '0;
`endif

  assign unit_load    = load_q;
  assign unit_first   = first_q;
  assign unit_last    = last_q;
  assign unit_sol_ack = EXT_RESET_N ? s_gnt : '0;
  assign sol_valid    = sval_q;
  assign sol_nonce    = snonce_q;
  assign busy         = (state_q == DISPATCH) || (state_q == DRAIN);
  assign done         = done_q;
  assign irq          = sval_q | done_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler.
// Load scoreboard plus direct solution-path checks.
module tb_nonce_scheduler;

  localparam int NU = 4;

`ifdef NONCE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [31:0]     nonce_base;
  logic [31:0]     nonce_limit;
  logic [NU-1:0]   unit_ready;
  logic [NU-1:0]   unit_load;
  logic [31:0]     unit_first;
  logic [31:0]     unit_last;
  logic [NU-1:0]   unit_sol_valid;
  logic [NU*32-1:0] unit_sol_nonce;
  logic [NU-1:0]   unit_sol_ack;
  logic            sol_valid;
  logic [31:0]     sol_nonce;
  logic            sol_read;
  logic            busy;
  logic            done;
  logic            irq;
  logic [31:0]     stat_slices;
  logic [31:0]     stat_solutions;

  typedef struct packed {
    logic [3:0]  unit;
    logic [31:0] first;
    logic [31:0] last;
  } load_t;

  load_t exp_q[$];
  load_t mon_e;
  int    n_chk;
  int    n_fail;
  int    load_cnt;
  int    done_cnt;
  int    lc0;
  int    dc0;

  nonce_scheduler #(.NUM_UNITS(NU), .SLICE_SIZE(256)) dut (
    .M1_CLK         (clk),
    .EXT_RESET_N    (rst_n),
    .start          (start),
    .abort          (abort),
    .nonce_base     (nonce_base),
    .nonce_limit    (nonce_limit),
    .unit_ready     (unit_ready),
    .unit_load      (unit_load),
    .unit_first     (unit_first),
    .unit_last      (unit_last),
    .unit_sol_valid (unit_sol_valid),
    .unit_sol_nonce (unit_sol_nonce),
    .unit_sol_ack   (unit_sol_ack),
    .sol_valid      (sol_valid),
    .sol_nonce      (sol_nonce),
    .sol_read       (sol_read),
    .busy           (busy),
    .done           (done),
    .irq            (irq),
    .stat_slices    (stat_slices),
    .stat_solutions (stat_solutions)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input int u, input logic [31:0] f,
                           input logic [31:0] l);
    load_t t;
    t.unit  = 4'(1 << u);
    t.first = f;
    t.last  = l;
    exp_q.push_back(t);
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] l);
    nonce_base  = b;
    nonce_limit = l;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_loads(input int target);
    for (int i = 0; i < 40 && load_cnt < target; i++) @(negedge clk);
    chk("wait_loads", load_cnt, target);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 60 && done_cnt < target; i++) @(negedge clk);
    chk("wait_done", done_cnt, target);
  endtask

  // scoreboard: every load must match the head of the expected queue
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (unit_load !== '0) begin
      load_cnt++;
      chk("load_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("load_unit", 32'(unit_load), 32'(mon_e.unit));
        chk("load_first", unit_first, mon_e.first);
        chk("load_last", unit_last, mon_e.last);
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; load_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sol_read = 1'b0;
    nonce_base = '0; nonce_limit = '0;
    unit_ready = '0; unit_sol_valid = '0; unit_sol_nonce = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_load", 32'(unit_load), 32'd0);
    chk("rst_first", unit_first, 32'd0);
    chk("rst_last", unit_last, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_sval", 32'(sol_valid), 32'd0);
    chk("rst_snonce", sol_nonce, 32'd0);
    chk("rst_stat_sl", stat_slices, 32'd0);

    // four full slices over four ready units
    unit_ready = 4'hF;
    push_load(0, 32'h000, 32'h0FF);
    push_load(1, 32'h100, 32'h1FF);
    push_load(2, 32'h200, 32'h2FF);
    push_load(3, 32'h300, 32'h3FF);
    lc0 = load_cnt; dc0 = done_cnt;
    pulse_start(32'h0, 32'h3FF);
    chk("busy_dispatch", 32'(busy), 32'd1);
    wait_done(dc0 + 1);
    chk("loads_before_done", load_cnt, lc0 + 4);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, dc0 + 1);
    chk("busy_after", 32'(busy), 32'd0);

    // top of nonce space, no 32-bit wrap
    push_load(0, 32'hFFFF_FF80, 32'hFFFF_FFFF);
    lc0 = load_cnt; dc0 = done_cnt;
    pulse_start(32'hFFFF_FF80, 32'hFFFF_FFFF);
    wait_done(dc0 + 1);
    repeat (4) @(negedge clk);
    chk("wrap_loads", load_cnt, lc0 + 1);
    chk("queue_empty1", exp_q.size(), 0);
    chk("stat_slices", stat_slices, STATS ? 32'd5 : 32'd0);

    // empty range: done two cycles after start
    lc0 = load_cnt;
    pulse_start(32'h10, 32'h0F);
    chk("empty_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    chk("empty_done_c2", 32'(done), 32'd1);
    chk("empty_irq", 32'(irq), 32'd1);
    @(negedge clk);
    chk("empty_done_c3", 32'(done), 32'd0);
    chk("empty_loads", load_cnt, lc0);

    // simultaneous solution reports from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    unit_sol_nonce = {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0};
    unit_sol_valid = 4'b1010;
    #1;
    chk("sol_ack_u1", 32'(unit_sol_ack), 32'h2);
    @(negedge clk);
    chk("sol_val_u1", 32'(sol_valid), 32'd1);
    chk("sol_nonce_u1", sol_nonce, 32'h1111_0001);
    chk("sol_irq", 32'(irq), 32'd1);
    unit_sol_valid[1] = 1'b0;
    #1;
    chk("sol_ack_hold", 32'(unit_sol_ack), 32'h0);
    sol_read = 1'b1;
    #1;
    chk("sol_ack_u3", 32'(unit_sol_ack), 32'h8);
    @(negedge clk);
    chk("sol_val_u3", 32'(sol_valid), 32'd1);
    chk("sol_nonce_u3", sol_nonce, 32'h3333_0003);
    unit_sol_valid[3] = 1'b0;
    @(negedge clk);
    chk("sol_cleared", 32'(sol_valid), 32'd0);
    chk("sol_irq_clr", 32'(irq), 32'd0);
    @(negedge clk);
    chk("sol_read_idle", 32'(sol_valid), 32'd0);
    chk("sol_nonce_kept", sol_nonce, 32'h3333_0003);
    sol_read = 1'b0;

    // abort after two loads
    push_load(0, 32'h000, 32'h0FF);
    push_load(1, 32'h100, 32'h1FF);
    lc0 = load_cnt; dc0 = done_cnt;
    pulse_start(32'h0, 32'hFFFF);
    wait_loads(lc0 + 2);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_loads", load_cnt, lc0 + 2);
    chk("abort_no_done", done_cnt, dc0);
    chk("stat_sols", stat_solutions, STATS ? 32'd2 : 32'd0);

    // reset mid-dispatch while a solution is held
    unit_sol_nonce[2*32 +: 32] = 32'h2222_0002;
    unit_sol_valid = 4'b0100;
    #1;
    chk("sol_ack_u2", 32'(unit_sol_ack), 32'h4);
    @(negedge clk);
    unit_sol_valid = '0;
    chk("sol_val_u2", 32'(sol_valid), 32'd1);
    push_load(2, 32'h000, 32'h0FF);
    push_load(3, 32'h100, 32'h1FF);
    lc0 = load_cnt;
    pulse_start(32'h0, 32'hFFFF);
    wait_loads(lc0 + 2);
    #2;
    rst_n = 1'b0;
    unit_sol_valid = 4'b0001;
    #1;
    chk("arst_load", 32'(unit_load), 32'd0);
    chk("arst_first", unit_first, 32'd0);
    chk("arst_last", unit_last, 32'd0);
    chk("arst_sval", 32'(sol_valid), 32'd0);
    chk("arst_snonce", sol_nonce, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_ack", 32'(unit_sol_ack), 32'd0);
    chk("arst_stat", stat_slices, 32'd0);
    @(negedge clk);
    unit_sol_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("queue_empty2", exp_q.size(), 0);
    push_load(0, 32'h1000, 32'h10FF);
    lc0 = load_cnt; dc0 = done_cnt;
    pulse_start(32'h1000, 32'h10FF);
    wait_done(dc0 + 1);
    chk("post_rst_loads", load_cnt, lc0 + 1);
    chk("queue_empty3", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 Parameter NUM_UNITS, default 4, is the number of hash units served (2..8).
REQ-002 Parameter SLICE_SIZE, default 256, is the nonces per dispatched slice (power of two, at most 2^16).
REQ-003 M1_CLK  in  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-004 EXT_RESET_N  in  1  reset; asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse that begins a job.
REQ-006 abort  in  1  level; terminates the job.
REQ-007 nonce_base  in  32  first nonce of the job; nonce_limit  in  32  last nonce, inclusive.
REQ-008 unit_ready  in  NUM_UNITS  unit idle and able to accept a slice.
REQ-009 unit_load  out  NUM_UNITS  one-hot, single-cycle slice strobe.
REQ-010 unit_first and unit_last  out  32 each  first and last nonce of the slice, valid with unit_load.
REQ-011 unit_sol_valid  in  NUM_UNITS  and unit_sol_nonce  in  NUM_UNITS*32  carry each unit's solution report; unit_sol_ack  out  NUM_UNITS  is a one-hot capture acknowledge.
REQ-012 sol_valid  out  1, sol_nonce  out  32, sol_read  in  1  form the host-side solution register.
REQ-013 busy, done, irq  out  1 each.
REQ-014 stat_slices, stat_solutions  out  32 each  statistics counters.

Function
REQ-015 FSM states SHALL be IDLE, DISPATCH, DRAIN and DONE.
REQ-016 In IDLE, start SHALL latch next=nonce_base and go to DISPATCH, or go to DONE if nonce_limit<nonce_base.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 In DISPATCH, each cycle with any unit_ready high SHALL grant exactly one unit, round-robin starting after the last granted unit.
REQ-019 A grant SHALL drive unit_first=next and unit_last=min(next+SLICE_SIZE-1, nonce_limit) using 33-bit arithmetic, with no 32-bit wrap.
REQ-020 After a grant, if unit_last==nonce_limit the FSM SHALL go to DRAIN; otherwise next+=SLICE_SIZE.
REQ-021 A unit granted in cycle N SHALL NOT be granted again before cycle N+2.
REQ-022 In DRAIN, when all unit_ready bits are high the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in DISPATCH and DRAIN.
REQ-025 abort SHALL force IDLE on the next edge from any state, with no further unit_load and no done pulse; abort has priority over start.
REQ-026 Solution capture SHALL run in every FSM state: when sol_valid=0, or sol_read=1 in the same cycle, one requesting unit SHALL be selected round-robin.
REQ-027 The selected unit's nonce SHALL be captured into sol_nonce and unit_sol_ack pulsed for it in that cycle.
REQ-028 sol_read with no capture SHALL clear sol_valid; sol_read while sol_valid=0 SHALL have no effect.
REQ-029 irq SHALL equal sol_valid OR done.

Reset
REQ-030 Reset SHALL force IDLE and clear both round-robin pointers (unit 0 has priority first).
REQ-031 Reset SHALL drive next=0 and every output to 0, including sol_nonce, unit_first, unit_last and the counters.
REQ-032 Reset mid-job SHALL discard the job with no done pulse.

Configuration
REQ-033 Macro NONCE_SCHED_STATS_EN defined: stat_slices SHALL increment per unit_load and stat_solutions per unit_sol_ack, both wrapping at 2^32 and cleared only by reset.
REQ-034 Macro NONCE_SCHED_STATS_EN undefined: both stat ports SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-035 Package decred_sched_pkg SHALL hold the FSM state enum, the NONCE_W=32 constant and the default SLICE_SIZE.
REQ-036 Sub-module rr_arbiter (parameter N; ports req, advance, grant one-hot) SHALL be instantiated twice, for dispatch and for solutions.

Verification
REQ-037 All ready, base 0x0, limit 0x3FF -> loads to units 0,1,2,3 on consecutive cycles with first=0x000/0x100/0x200/0x300, last=first+0xFF; done pulses once all units are ready.
REQ-038 base 0xFFFFFF80, limit 0xFFFFFFFF -> exactly one load, first=0xFFFFFF80, last=0xFFFFFFFF, no wrap to 0.
REQ-039 base 0x10, limit 0x0F -> no loads; done=1 exactly 2 cycles after start.
REQ-040 Units 1 and 3 report simultaneously from reset -> unit 1 captured and acked; sol_read -> unit 3 captured in the same cycle, sol_valid stays 1.
REQ-041 Abort after 2 loads, limit 0xFFFF -> busy=0 next cycle, no further loads, done never asserted.
REQ-042 EXT_RESET_N low mid-DISPATCH with sol_valid=1 -> all outputs 0 asynchronously; the next job's first grant goes to unit 0.
